// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 4-bit restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DIV_ITERATIONS = 4;
  localparam logic [3:0]  DBZ_QUOTIENT   = 4'hF;

endpackage

// File: rtl/subtractor_4bit.sv
// 4-bit subtractor: diff = a - b - bin, bout is the borrow out of the MSB.
module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
  assign diff = full[3:0];
  assign bout = full[4];

endmodule

// File: rtl/divider_4bit_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per CALC cycle,
// divide-by-zero short-circuits straight to DONE.
module divider_4bit_seq
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  localparam int unsigned CntW = $clog2(DIV_ITERATIONS);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_ITERATIONS - 1);

  div_state_e    state_q, state_d;
  logic [3:0]    q_q, q_d;
  logic [3:0]    r_q, r_d;
  logic [3:0]    d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]    quotient_q, quotient_d;
  logic [3:0]    remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [4:0] s;
  logic [3:0] diff;
  logic       bout;
  logic       take;
  logic [3:0] q_next;
  logic [3:0] r_next;

  // Shifted partial remainder; bit 4 set means it already exceeds any 4-bit divisor.
  assign s = {r_q, q_q[3]};

  subtractor_4bit u_sub (
    .a   (s[3:0]),
    .b   (d_q),
    .bin (1'b0),
    .diff(diff),
    .bout(bout)
  );

  assign take   = s[4] | ~bout;
  assign q_next = {q_q[2:0], take};
  assign r_next = take ? diff : s[3:0];

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != 4'd0) begin
            q_d     = dividend;
            d_d     = divisor;
            r_d     = 4'd0;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            quotient_d  = DBZ_QUOTIENT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      CALC: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          quotient_d  = q_next;
          remainder_d = r_next;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= 4'd0;
      r_q         <= 4'd0;
      d_q         <= 4'd0;
      cnt_q       <= '0;
      quotient_q  <= 4'd0;
      remainder_q <= 4'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
